// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encodings, address and width constants.
// Used by router_fsm, router_reg and the benches.
package router_pkg;

    localparam int         DATA_WIDTH   = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'b000,
        LOAD_FIRST_DATA    = 3'b001,
        LOAD_DATA          = 3'b010,
        WAIT_TILL_EMPTY    = 3'b011,
        FIFO_FULL_STATE    = 3'b100,
        LOAD_AFTER_FULL    = 3'b101,
        LOAD_PARITY        = 3'b110,
        CHECK_PARITY_ERROR = 3'b111
    } fsm_state_t;

endpackage

// File: rtl/router_reg_if.sv
// Signal bundle between the router FSM/input side (master) and the datapath
// register block (slave).
interface router_reg_if
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);
    // There is no valid/ready pair here: data_in is qualified by pkt_valid plus
    // the one-hot FSM strobes, and dout is qualified downstream by write_enb.
    logic [WIDTH-1:0] data_in;
    logic             pkt_valid;
    logic             fifo_full;
    logic             detect_add;
    logic             lfd_state;
    logic             ld_state;
    logic             laf_state;
    logic             full_state;
    logic             rst_int_reg;
    logic [WIDTH-1:0] dout;
    logic             parity_done;
    logic             low_pkt_valid;
    logic             err;

    modport master (
        output data_in, pkt_valid, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  data_in, pkt_valid, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity of header and payload, capture of the received parity
// byte, and the mismatch flag evaluated once the packet is complete.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             full_state,
    input  logic             pkt_valid,
    input  logic             parity_done,
    input  logic [WIDTH-1:0] hdr,
    input  logic [WIDTH-1:0] data_in,
    output logic             err
);

    logic [WIDTH-1:0] int_par;
    logic [WIDTH-1:0] pkt_par;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_par <= '0;
        end else if (detect_add) begin
            int_par <= '0;
        end else if (lfd_state) begin
            int_par <= int_par ^ hdr;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_par <= int_par ^ data_in;
        end
    end

    // The parity byte is the one LOAD_DATA byte seen with pkt_valid low,
    // captured even if the FIFO is full at that moment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_par <= '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_par <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_par != pkt_par);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register block: header latch, output byte mux with a one-byte
// holding register for FIFO-full stalls, and packet completion flags.
module router_reg
    import router_pkg::*;
#(
    parameter int         WIDTH        = DATA_WIDTH,
    parameter logic [1:0] INVALID_ADDR = ADDR_INVALID
) (
    input  logic        clock,
    input  logic        reset,
    router_reg_if.slave bus
);

    logic [WIDTH-1:0] hdr;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] dout_r;
    logic             parity_done_r;
    logic             low_pkt_valid_r;
    logic             err_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr <= '0;
        end else if (bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != INVALID_ADDR)) begin
            hdr <= bus.data_in;
        end
    end

    // A byte arriving while the FIFO is full parks in hold and is replayed
    // in LOAD_AFTER_FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_r <= '0;
            hold   <= '0;
        end else if (bus.lfd_state) begin
            dout_r <= hdr;
        end else if (bus.ld_state && !bus.fifo_full) begin
            dout_r <= bus.data_in;
        end else if (bus.ld_state && bus.fifo_full) begin
            hold <= bus.data_in;
        end else if (bus.laf_state) begin
            dout_r <= hold;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done_r <= 1'b0;
        end else if (bus.detect_add) begin
            parity_done_r <= 1'b0;
        end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (bus.laf_state && low_pkt_valid_r && !parity_done_r)) begin
            parity_done_r <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_pkt_valid_r <= 1'b0;
        end else if (bus.rst_int_reg) begin
            low_pkt_valid_r <= 1'b0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            low_pkt_valid_r <= 1'b1;
        end
    end

    router_parity_acc #(.WIDTH(WIDTH)) u_parity (
        .clock       (clock),
        .reset       (reset),
        .detect_add  (bus.detect_add),
        .lfd_state   (bus.lfd_state),
        .ld_state    (bus.ld_state),
        .full_state  (bus.full_state),
        .pkt_valid   (bus.pkt_valid),
        .parity_done (parity_done_r),
        .hdr         (hdr),
        .data_in     (bus.data_in),
        .err         (err_w)
    );

    assign bus.dout          = dout_r;
    assign bus.parity_done   = parity_done_r;
    assign bus.low_pkt_valid = low_pkt_valid_r;
    assign bus.err           = err_w;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: directed and randomized packets checked against a
// packet-level model (expected output byte queue, XOR parity per packet).
module tb_router_reg;
    import router_pkg::*;

    localparam int W = DATA_WIDTH;

    logic clock = 1'b0;
    logic reset;

    router_reg_if #(.WIDTH(W)) bus ();

    router_reg #(.WIDTH(W), .INVALID_ADDR(ADDR_INVALID)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_dout;

    // Present one FSM state's strobes plus inputs for a single clock cycle.
    task automatic drive(input fsm_state_t st, input logic [W-1:0] d, input logic pv, input logic ff);
        bus.detect_add  = (st == DECODE_ADDRESS);
        bus.lfd_state   = (st == LOAD_FIRST_DATA);
        bus.ld_state    = (st == LOAD_DATA);
        bus.laf_state   = (st == LOAD_AFTER_FULL);
        bus.full_state  = (st == FIFO_FULL_STATE);
        bus.rst_int_reg = (st == CHECK_PARITY_ERROR);
        bus.data_in     = d;
        bus.pkt_valid   = pv;
        bus.fifo_full   = ff;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(WAIT_TILL_EMPTY, '0, 1'b0, 1'b0);
        drive(WAIT_TILL_EMPTY, '0, 1'b0, 1'b0);
        vectors++; if (bus.dout !== '0) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        vectors++; if (bus.parity_done !== 1'b0) begin miscompares++; $display("FAIL reset_parity_done got=%b exp=0", bus.parity_done); end
        vectors++; if (bus.low_pkt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_low_pkt_valid got=%b exp=0", bus.low_pkt_valid); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        @(negedge clock);
        reset = 1'b0;
        last_dout = '0;
    endtask

    // One full packet. par_xor corrupts the parity byte; full_mode 0 = never
    // full, 1 = random full stalls on payload, 2 = full on the parity byte.
    task automatic test_packet(input logic [W-1:0] hdr_b, input logic [W-1:0] pay[$],
                               input logic [W-1:0] par_xor, input int full_mode);
        logic [W-1:0] par;
        logic [W-1:0] sent;
        logic [W-1:0] exp;
        logic         ff;
        par = hdr_b;
        foreach (pay[i]) par = par ^ pay[i];
        sent = par ^ par_xor;
        exp_q.delete();
        exp_q.push_back(hdr_b);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(sent);

        drive(DECODE_ADDRESS, hdr_b, 1'b1, 1'b0);
        vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL da_dout_hold got=%h exp=%h", bus.dout, last_dout); end
        vectors++; if (bus.parity_done !== 1'b0) begin miscompares++; $display("FAIL da_parity_done_clr got=%b exp=0", bus.parity_done); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL da_err_clr got=%b exp=0", bus.err); end

        drive(LOAD_FIRST_DATA, pay[0], 1'b1, 1'b0);
        exp = exp_q.pop_front();
        vectors++; if (bus.dout !== exp) begin miscompares++; $display("FAIL lfd_dout got=%h exp=%h", bus.dout, exp); end
        last_dout = exp;

        for (int i = 0; i < pay.size(); i++) begin
            ff = (full_mode == 1) && ($urandom_range(0, 2) == 0);
            drive(LOAD_DATA, pay[i], 1'b1, ff);
            if (ff) begin
                vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL full_dout_hold got=%h exp=%h", bus.dout, last_dout); end
                drive(FIFO_FULL_STATE, W'($urandom), 1'b1, 1'b1);
                vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL fullst_dout_hold got=%h exp=%h", bus.dout, last_dout); end
                drive(LOAD_AFTER_FULL, W'($urandom), 1'b1, 1'b0);
            end
            exp = exp_q.pop_front();
            vectors++; if (bus.dout !== exp) begin miscompares++; $display("FAIL payload_dout idx=%0d got=%h exp=%h", i, bus.dout, exp); end
            last_dout = exp;
        end

        ff = (full_mode == 2);
        drive(LOAD_DATA, sent, 1'b0, ff);
        vectors++; if (bus.low_pkt_valid !== 1'b1) begin miscompares++; $display("FAIL low_pkt_valid_set got=%b exp=1", bus.low_pkt_valid); end
        if (ff) begin
            vectors++; if (bus.parity_done !== 1'b0) begin miscompares++; $display("FAIL pd_deferred got=%b exp=0", bus.parity_done); end
            vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL par_full_dout_hold got=%h exp=%h", bus.dout, last_dout); end
            drive(FIFO_FULL_STATE, sent, 1'b0, 1'b1);
            vectors++; if (bus.parity_done !== 1'b0) begin miscompares++; $display("FAIL pd_fullst got=%b exp=0", bus.parity_done); end
            drive(LOAD_AFTER_FULL, sent, 1'b0, 1'b0);
        end
        exp = exp_q.pop_front();
        vectors++; if (bus.dout !== exp) begin miscompares++; $display("FAIL parity_dout got=%h exp=%h", bus.dout, exp); end
        last_dout = exp;
        vectors++; if (bus.parity_done !== 1'b1) begin miscompares++; $display("FAIL parity_done_set got=%b exp=1", bus.parity_done); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_early got=%b exp=0", bus.err); end

        drive(CHECK_PARITY_ERROR, sent, 1'b0, 1'b0);
        vectors++; if (bus.low_pkt_valid !== 1'b0) begin miscompares++; $display("FAIL low_pkt_valid_clr got=%b exp=0", bus.low_pkt_valid); end
        vectors++; if (bus.err !== (par_xor != '0)) begin miscompares++; $display("FAIL err_value got=%b exp=%b", bus.err, (par_xor != '0)); end

        drive(WAIT_TILL_EMPTY, W'($urandom), 1'b0, 1'b0);
        vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL idle_dout_hold got=%h exp=%h", bus.dout, last_dout); end
        vectors++; if (bus.err !== (par_xor != '0)) begin miscompares++; $display("FAIL err_hold got=%b exp=%b", bus.err, (par_xor != '0)); end
    endtask

    task automatic test_normal_packet();
        logic [W-1:0] p[$];
        p = {8'h11, 8'h22};
        test_packet(8'h05, p, 8'h00, 0);
    endtask

    // Parity byte 00 instead of 36; the next packet's header clears err.
    task automatic test_bad_parity();
        logic [W-1:0] p[$];
        p = {8'h11, 8'h22};
        test_packet(8'h05, p, 8'h36, 0);
        test_packet(8'h05, p, 8'h00, 0);
    endtask

    task automatic test_fifo_full();
        logic [W-1:0] p[$];
        p = {8'hAA, 8'h3C, 8'h71, 8'h0F};
        test_packet(8'h06, p, 8'h00, 1);
        p = {8'h10, 8'h20};
        test_packet(8'h01, p, 8'h00, 2);
        test_packet(8'h02, p, 8'h5C, 2);
    endtask

    task automatic test_invalid_header();
        logic [W-1:0] p[$];
        p = {8'h11, 8'h22};
        test_packet(8'h05, p, 8'h00, 0);
        drive(DECODE_ADDRESS, 8'h07, 1'b1, 1'b0);
        vectors++; if (bus.dout !== last_dout) begin miscompares++; $display("FAIL inv_dout_hold got=%h exp=%h", bus.dout, last_dout); end
        drive(DECODE_ADDRESS, 8'h0A, 1'b0, 1'b0);
        drive(LOAD_FIRST_DATA, 8'h33, 1'b1, 1'b0);
        vectors++; if (bus.dout !== 8'h05) begin miscompares++; $display("FAIL inv_hdr_kept got=%h exp=05", bus.dout); end
        last_dout = 8'h05;
    endtask

    task automatic test_random_packets();
        logic [W-1:0] p[$];
        logic [W-1:0] hdr_b;
        logic [W-1:0] px;
        for (int n = 0; n < 30; n++) begin
            p.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) p.push_back(W'($urandom));
            hdr_b = {6'($urandom), 2'($urandom_range(0, 2))};
            px = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 255)) : '0;
            test_packet(hdr_b, p, px, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_async_reset();
        drive(DECODE_ADDRESS, 8'h46, 1'b1, 1'b0);
        drive(LOAD_FIRST_DATA, 8'h9C, 1'b1, 1'b0);
        drive(LOAD_DATA, 8'h9C, 1'b1, 1'b0);
        drive(LOAD_DATA, 8'h00, 1'b0, 1'b0);
        drive(WAIT_TILL_EMPTY, 8'h00, 1'b0, 1'b0);
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL pre_reset_err got=%b exp=1", bus.err); end
        bus.ld_state  = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'hE1;
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (bus.dout !== '0) begin miscompares++; $display("FAIL async_dout got=%h exp=00", bus.dout); end
        vectors++; if (bus.parity_done !== 1'b0) begin miscompares++; $display("FAIL async_parity_done got=%b exp=0", bus.parity_done); end
        vectors++; if (bus.low_pkt_valid !== 1'b0) begin miscompares++; $display("FAIL async_low_pkt_valid got=%b exp=0", bus.low_pkt_valid); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL async_err got=%b exp=0", bus.err); end
        #2;
        reset = 1'b0;
        drive(LOAD_FIRST_DATA, 8'h77, 1'b1, 1'b0);
        vectors++; if (bus.dout !== '0) begin miscompares++; $display("FAIL async_hdr_cleared got=%h exp=00", bus.dout); end
        last_dout = '0;
    endtask

    initial begin
        test_reset();
        test_normal_packet();
        test_bad_parity();
        test_fifo_full();
        test_invalid_header();
        test_random_packets();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register block of the 1x3 router, directly downstream of router_fsm.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the raw input byte stream.
- Produces the byte written to the selected output FIFO (dout), and returns parity_done and low_pkt_valid to the FSM.
- Computes the running XOR parity of each packet, compares it with the received parity byte, and flags err.

Parameters:
- WIDTH, 8, byte width of data_in/dout; header address field is always bits [1:0].
- INVALID_ADDR, 2'b11, header address value that is never latched.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  packet byte stream: header, then payload, then parity byte.
- pkt_valid  in  1  high during header and payload; low on the parity byte.
- fifo_full  in  1  selected output FIFO full.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid.
- dout  out  WIDTH  byte to FIFO; qualified externally by write_enb.
- parity_done  out  1  parity byte captured; packet complete.
- low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA.
- err  out  1  parity mismatch for the last packet.

Behaviour:
- Reset: dout, parity_done, low_pkt_valid and err go to 0. Internal hdr, hold, int_par and pkt_par also go to 0. Reset takes effect immediately, including mid-packet.
- Header capture: when detect_add && pkt_valid && data_in[1:0]!=INVALID_ADDR, hdr<=data_in. Otherwise hdr holds.
- dout, by priority:
  - lfd_state: dout<=hdr.
  - ld_state && !fifo_full: dout<=data_in.
  - ld_state && fifo_full: hold<=data_in and dout holds. This captures the byte that arrived as the FIFO filled.
  - laf_state: dout<=hold.
  - Otherwise dout holds.
- Latency: one cycle from data_in to dout. The header appears on dout in the LOAD_FIRST_DATA cycle.
- Internal parity int_par:
  - detect_add: int_par<=0.
  - lfd_state: int_par<=int_par^hdr.
  - ld_state && pkt_valid && !full_state: int_par<=int_par^data_in.
  - Otherwise int_par holds.
- Packet parity: ld_state && !pkt_valid: pkt_par<=data_in.
- parity_done:
  - Set when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done).
  - Cleared on detect_add. Detect_add takes priority over set.
- low_pkt_valid:
  - Set when ld_state && !pkt_valid.
  - Cleared when rst_int_reg. rst_int_reg takes priority over set.
- err:
  - Cleared on detect_add.
  - While parity_done==1, err<=(int_par!=pkt_par), so err is valid one cycle after parity_done rises.
  - err holds until the next detect_add.
- Boundary cases:
  - Header with address 2'b11: hdr is unchanged; the FSM never leaves DECODE_ADDRESS.
  - fifo_full on the parity byte: parity_done is deferred until the LOAD_AFTER_FULL cycle with low_pkt_valid=1. pkt_par is still captured in the LOAD_DATA cycle.
  - Back-to-back packets: detect_add clears int_par, parity_done and err in the same edge that a new header is captured.
  - Soft reset at the FSM returns it to DECODE_ADDRESS; detect_add then reinitialises this block. No soft-reset port is needed.
  - More than one state strobe high at once is illegal and is not checked; the dout priority above governs.

Decomposition:
- Shared package router_pkg holds:
  - the FSM state encodings: DECODE_ADDRESS=3'b000 through CHECK_PARITY_ERROR=3'b111;
  - ADDR_INVALID=2'b11;
  - DATA_WIDTH=8.
  These are reused by router_fsm and the benches.
- One sub-module, router_parity_acc, contains int_par, pkt_par and the err compare.
- dout/hold/hdr muxing stays in router_reg.

Test Plan:
- Normal packet: header 8'h05, payload 8'h11 and 8'h22, parity byte 8'h36, strobes sequenced DA-LFD-LD-LD-LD(pkt_valid=0)-CPE.
  -> dout=05, 11, 22 on consecutive cycles; int_par=36; parity_done=1; low_pkt_valid=1 then 0 at rst_int_reg; err=0.
- Bad parity: same packet with parity byte 8'h00.
  -> err=1 one cycle after parity_done; err clears on the next detect_add.
- FIFO full mid-payload: data_in=8'hAA with ld_state and fifo_full=1, then full_state, then laf_state.
  -> dout holds its prior value, then dout=AA in the laf cycle; int_par excludes the full_state cycle.
- Full on parity byte: LD with pkt_valid=0 and fifo_full=1, data 8'h5C.
  -> pkt_par=5C, low_pkt_valid=1, parity_done=0; in the next laf_state cycle parity_done=1.
- Invalid header: detect_add with pkt_valid=1 and data_in=8'h07 after a prior hdr=8'h05.
  -> hdr stays 05; a following lfd_state gives dout=05.
- Async reset mid-packet: assert reset between clock edges during LD.
  -> dout, parity_done, low_pkt_valid and err are 0 immediately, with no clock edge required.
